pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed EX/MEM latch in the five-stage MIPS core; one instance serves any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, stall, flush and bubble insertion.
- Adds a two-entry skid buffer so `in_ready` comes straight from a flop, with no combinational path from `out_ready`.
- Computes pc+4 internally instead of carrying it as a separate port.

---
 rtl/pipe_stage_reg.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer, stall, flush and bubbles.
// Optional STAGE_PERF_CNT_EN adds bubble_cnt / stall_cnt performance counters.
module pipe_stage_reg #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_CH   = 2,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]        in_a2,
  input  logic [ADDR_W-1:0]        in_a3,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc4,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_a2,
  output logic [ADDR_W-1:0]        out_a3
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [31:0]              bubble_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  // state   | meaning
  // S_EMPTY | no entry held, outputs show a bubble
  // S_ONE   | main holds the head entry, skid empty
  // S_FULL  | main holds head, skid holds the next entry, in_ready low
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state, state_nxt;

  logic [31:0]              main_pc;
  logic [NUM_CH*DATA_W-1:0] main_data;
  logic [ADDR_W-1:0]        main_a2, main_a3;
  logic [31:0]              skid_pc;
  logic [NUM_CH*DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0]        skid_a2, skid_a3;

  logic take, give;
  logic load_main_in, load_main_skid, load_skid, clear_main, clear_skid;

  assign take = in_valid & in_ready;
  assign give = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != S_FULL);
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      state_nxt  = S_EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (take) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (take && give) begin
            load_main_in = 1'b1;
          end else if (take) begin
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end else if (give) begin
            state_nxt  = S_EMPTY;
            clear_main = 1'b1;
          end
        end
        S_FULL: begin
          if (give) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
          end
        end
        default: begin
          state_nxt  = S_EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  // Bubbles zero the writer fields but keep the last valid PC on out_pc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pc   <= PC_RESET;
      main_data <= '0;
      main_a2   <= '0;
      main_a3   <= '0;
    end else if (clear_main) begin
      main_data <= '0;
      main_a2   <= '0;
      main_a3   <= '0;
    end else if (load_main_in) begin
      main_pc   <= in_pc;
      main_data <= in_data;
      main_a2   <= in_a2;
      main_a3   <= in_a3;
    end else if (load_main_skid) begin
      main_pc   <= skid_pc;
      main_data <= skid_data;
      main_a2   <= skid_a2;
      main_a3   <= skid_a3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_pc   <= '0;
      skid_data <= '0;
      skid_a2   <= '0;
      skid_a3   <= '0;
    end else if (clear_skid) begin
      skid_pc   <= '0;
      skid_data <= '0;
      skid_a2   <= '0;
      skid_a3   <= '0;
    end else if (load_skid) begin
      skid_pc   <= in_pc;
      skid_data <= in_data;
      skid_a2   <= in_a2;
      skid_a3   <= in_a3;
    end
  end

  assign out_valid = (state != S_EMPTY);
  assign out_pc    = main_pc;
  assign out_pc4   = main_pc + 32'd4;
  assign out_data  = main_data;
  assign out_a2    = main_a2;
  assign out_a3    = main_a3;

`ifdef STAGE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!out_valid) bubble_cnt <= bubble_cnt + 32'd1;
      if (stall && out_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a driver pushes accepted entries into an expected FIFO,
// a negedge monitor compares the DUT head against it and pops on each hand-off.
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          NC  = 2;
  localparam int          AW  = 5;
  localparam logic [31:0] PCR = 32'h0000_3000;

  typedef struct {
    logic [31:0]      pc;
    logic [NC*DW-1:0] data;
    logic [AW-1:0]    a2;
    logic [AW-1:0]    a3;
  } ent_t;

  logic             clk, reset;
  logic             in_valid, in_ready;
  logic [31:0]      in_pc;
  logic [NC*DW-1:0] in_data;
  logic [AW-1:0]    in_a2, in_a3;
  logic             stall, flush;
  logic             out_valid, out_ready;
  logic [31:0]      out_pc, out_pc4;
  logic [NC*DW-1:0] out_data;
  logic [AW-1:0]    out_a2, out_a3;

  pipe_stage_reg #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_a2(in_a2), .in_a3(in_a3), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_data(out_data), .out_a2(out_a2), .out_a3(out_a3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  ent_t        exp_q[$];
  logic [31:0] last_pc  = PCR;

  function automatic logic [31:0] plus4(input logic [31:0] pc);
    logic [31:0] r;
    r = pc + 32'd4;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: the expected FIFO here mirrors what the stage holds between edges.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        last_pc = exp_q[0].pc;
        chk("head_pc", out_pc, exp_q[0].pc);
        chk("head_pc4", out_pc4, plus4(exp_q[0].pc));
        chk("head_data", out_data, exp_q[0].data);
        chk("head_a2", out_a2, exp_q[0].a2);
        chk("head_a3", out_a3, exp_q[0].a3);
        if (out_valid && out_ready && !stall) void'(exp_q.pop_front());
      end else begin
        chk("bubble_pc", out_pc, last_pc);
        chk("bubble_pc4", out_pc4, plus4(last_pc));
        chk("bubble_data", out_data, '0);
        chk("bubble_a3", out_a3, '0);
      end
    end
  end

  // One clock of stimulus: drive just after an edge, account for the hand-off at the next edge.
  task automatic cycle(input bit iv, input logic [31:0] pc, input bit st, input bit fl,
                       input bit ordy, output bit taken);
    ent_t e;
    e.pc   = pc;
    e.data = {$urandom, $urandom};
    e.a2   = AW'($urandom);
    e.a3   = AW'($urandom);
    in_valid  = iv;
    in_pc     = pc;
    in_data   = e.data;
    in_a2     = e.a2;
    in_a3     = e.a3;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    #1;
    taken = iv && in_ready && reset && !fl;
    @(posedge clk);
    if (reset) begin
      if (fl) exp_q.delete();
      else if (taken) exp_q.push_back(e);
    end
    #1;
  endtask

  // Present pc until accepted, with a bounded number of attempts.
  task automatic send(input logic [31:0] pc, input bit ordy);
    bit t;
    t = 1'b0;
    for (int i = 0; i < 20 && !t; i++) cycle(1'b1, pc, 1'b0, 1'b0, ordy, t);
    if (!t) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_taken required=taken pc=%h", pc);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit t;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, ordy, t);
  endtask

  initial begin
    bit t;
    reset = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_data = '0; in_a2 = '0; in_a3 = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset then idle
    idle(3, 1'b1);
    chk("idle_pc", out_pc, 32'h3000);
    chk("idle_pc4", out_pc4, 32'h3004);
    chk("idle_in_ready", in_ready, 1'b1);

    // streaming
    send(32'h3000, 1'b1);
    send(32'h3004, 1'b1);
    send(32'h3008, 1'b1);
    idle(2, 1'b1);

    // back-pressure
    send(32'h3000, 1'b0);
    send(32'h3004, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    cycle(1'b1, 32'h3008, 1'b0, 1'b0, 1'b0, t);
    chk("bp_held", t, 1'b0);
    send(32'h3008, 1'b1);
    idle(3, 1'b1);

    // stall while full
    send(32'h3000, 1'b0);
    send(32'h3004, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, t);
      chk("stall_head", out_pc, 32'h3000);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    idle(3, 1'b1);

    // flush while full, with stall also asserted
    send(32'h3000, 1'b0);
    send(32'h3004, 1'b0);
    cycle(1'b1, 32'h300C, 1'b1, 1'b1, 1'b0, t);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_a3", out_a3, '0);
    chk("flush_data", out_data, '0);
    chk("flush_in_ready", in_ready, 1'b1);
    idle(2, 1'b1);

    // asynchronous reset mid-stream
    send(32'h4000, 1'b0);
    send(32'h4004, 1'b0);
    #2 reset = 1'b0;
    exp_q.delete();
    last_pc = PCR;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_pc", out_pc, PCR);
    chk("arst_pc4", out_pc4, plus4(PCR));
    chk("arst_data", out_data, '0);
    chk("arst_a2", out_a2, '0);
    chk("arst_a3", out_a3, '0);
    @(posedge clk);
    #1 reset = 1'b1;

    // pc4 wrap-around
    send(32'hFFFF_FFFC, 1'b1);
    chk("wrap_pc4", out_pc4, 32'h0000_0000);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) < 75, {$urandom} & 32'hFFFF_FFFC,
            $urandom_range(99) < 20, $urandom_range(99) < 5,
            $urandom_range(99) < 70, t);
    end
    idle(4, 1'b1);
    chk("drained", exp_q.size(), 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
